// File: rtl/frag_sched_if.sv
// Handshake bundle for frag_sched: requester side (valid/data/ready per requester)
// and the serialized fragment stream with its owner id.
interface frag_sched_if #(
  parameter int NREQ   = 4,
  parameter int IWIDTH = 288,
  parameter int OWIDTH = 36
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*IWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   out_valid;
  logic [OWIDTH-1:0]      out_data;
  logic [IDW-1:0]         out_id;
  logic                   out_last;
  logic                   out_ready;

  modport master (output req_valid, req_data, out_ready,
                  input  req_ready, out_valid, out_data, out_id, out_last);
  modport slave  (input  req_valid, req_data, out_ready,
                  output req_ready, out_valid, out_data, out_id, out_last);
endinterface

// File: rtl/frag_sched.sv
// Round-robin arbiter feeding a wide-to-narrow serializer, LSB fragment first.
// Define FRAG_SCHED_B2B_EN to re-arbitrate on the last accepted fragment (no idle bubble).
module frag_sched #(
  parameter int NREQ   = 4,
  parameter int IWIDTH = 288,
  parameter int OWIDTH = 36
) (
  input  logic        clk,
  input  logic        reset,
  frag_sched_if.slave bus
);
  localparam int AMOUNT = IWIDTH / OWIDTH;
  localparam int CW     = $clog2(AMOUNT);
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef FRAG_SCHED_B2B_EN
  localparam bit B2B_EN = 1'b1;
`else
  localparam bit B2B_EN = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IWIDTH-1:0] word_q, word_d;

  logic [IWIDTH-1:0] slice [NREQ];
  logic [OWIDTH-1:0] frag  [AMOUNT];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = bus.req_data[i*IWIDTH +: IWIDTH];
  end
  for (genvar j = 0; j < AMOUNT; j++) begin : g_frag
    assign frag[j] = word_q[j*OWIDTH +: OWIDTH];
  end

  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx, cand;
  logic           last_acc, arb_en;

  // Rotating search starting just after ptr; ptr itself is visited last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_vld && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    word_d   = word_q;
    bus.req_ready = '0;
    last_acc = (state_q == SEND) && bus.out_ready && (cnt_q == CW'(AMOUNT-1));
    arb_en   = !reset && ((state_q == IDLE) || (B2B_EN && last_acc));

    if (state_q == SEND && bus.out_ready) begin
      cnt_d = last_acc ? '0 : cnt_q + 1'b1;
      if (last_acc) state_d = IDLE;
    end

    if (arb_en && gnt_vld) begin
      bus.req_ready[gnt_idx] = 1'b1;
      word_d  = slice[gnt_idx];
      id_d    = gnt_idx;
      ptr_d   = gnt_idx;
      cnt_d   = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= IDW'(NREQ-1);
      id_q    <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      word_q  <= word_d;
    end
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign bus.out_valid = (state_q == SEND) && !reset;
  assign bus.out_last  = (state_q == SEND) && (cnt_q == CW'(AMOUNT-1)) && !reset;
  assign bus.out_data  = frag[cnt_q];
  assign bus.out_id    = id_q;
endmodule
